// File: rtl/updn_counter_param.sv
// Parameterised up/down counter with variable step, wrap or saturate at the
// MAX_VAL/0 bounds, synchronous load, and a one-cycle boundary event pulse.
module updn_counter_param #(
    parameter int          WIDTH   = 16,
    parameter int unsigned MAX_VAL = (2**WIDTH) - 1,
    parameter int          STEP_W  = 4,
    parameter bit          SAT     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  counter,
    output logic              at_max,
    output logic              at_zero,
    output logic              ovf
);

    // One extra bit so counter+step and counter+(MAX_VAL+1) never overflow.
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_X = MAX_X + {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_N = MAX_X[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_r;
    logic             ovf_r;
    logic [WIDTH-1:0] nxt_cnt_s;
    logic             nxt_ovf_s;
    logic [WIDTH:0]   cnt_x_s;
    logic [WIDTH:0]   step_x_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   wrap_s;

    assign cnt_x_s  = {1'b0, cnt_r};
    assign step_x_s = (WIDTH+1)'(step);
    assign sum_s    = cnt_x_s + step_x_s;
    assign wrap_s   = cnt_x_s + MOD_X - step_x_s;

    // Next count and boundary event; load beats enable, otherwise hold.
    always_comb begin
        nxt_cnt_s = cnt_r;
        nxt_ovf_s = 1'b0;
        if (load) begin
            if ({1'b0, load_val} > MAX_X) begin
                nxt_cnt_s = MAX_N;
            end else begin
                nxt_cnt_s = load_val;
            end
        end else if (enable) begin
            if (up) begin
                if (sum_s > MAX_X) begin
                    nxt_ovf_s = 1'b1;
                    nxt_cnt_s = SAT ? MAX_N : WIDTH'(sum_s - MOD_X);
                end else begin
                    nxt_cnt_s = sum_s[WIDTH-1:0];
                end
            end else begin
                if (step_x_s > cnt_x_s) begin
                    nxt_ovf_s = 1'b1;
                    nxt_cnt_s = SAT ? {WIDTH{1'b0}} : wrap_s[WIDTH-1:0];
                end else begin
                    nxt_cnt_s = WIDTH'(cnt_x_s - step_x_s);
                end
            end
        end else begin
            nxt_cnt_s = cnt_r;
        end
    end

    // Count and event registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            cnt_r <= nxt_cnt_s;
            ovf_r <= nxt_ovf_s;
        end
    end

    assign counter = cnt_r;
    assign ovf     = ovf_r;
    assign at_max  = (cnt_r == MAX_N);
    assign at_zero = (cnt_r == {WIDTH{1'b0}});

    updn_counter_param_chk #(
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .load   (load),
        .step   (step)
    );

endmodule

// Simulation checker: flags enabled steps larger than one full revolution.
module updn_counter_param_chk #(
    parameter int unsigned MAX_VAL = 32'd15,
    parameter int          STEP_W  = 4
) (
    input logic              clk,
    input logic              rst_n,
    input logic              enable,
    input logic              load,
    input logic [STEP_W-1:0] step
);

    logic [63:0] step_w_s;
    logic [63:0] lim_w_s;

    assign step_w_s = 64'(step);
    assign lim_w_s  = 64'(MAX_VAL) + 64'd1;

    a_step_range: assert property (@(posedge clk)
        (rst_n && enable && !load) |-> (step_w_s <= lim_w_s));

endmodule

// File: tb/tb_updn_counter_param.sv
// Directed bench: a wrapping and a saturating counter (WIDTH=4, MAX_VAL=9)
// driven from shared inputs, checked against hand-computed values.
module tb_updn_counter_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] step = 4'd0;

    logic [3:0] w_cnt, s_cnt;
    logic       w_max, w_zero, w_ovf;
    logic       s_max, s_zero, s_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    updn_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP_W(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .step(step), .counter(w_cnt), .at_max(w_max),
        .at_zero(w_zero), .ovf(w_ovf)
    );

    updn_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP_W(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .step(step), .counter(s_cnt), .at_max(s_max),
        .at_zero(s_zero), .ovf(s_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd1; load = 1'b0;
        tick(); tick();
        n_tests++; if (w_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", w_cnt); end
        n_tests++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0d exp 0", w_ovf); end
        n_tests++; if (w_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %0d exp 1", w_zero); end
        n_tests++; if (w_max !== 1'b0) begin n_fail++; $display("FAIL reset_max got %0d exp 0", w_max); end
        n_tests++; if (s_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_sat_cnt got %0d exp 0", s_cnt); end
    endtask

    task automatic test_wrap_up();
        rst_n = 1'b1; enable = 1'b0; load = 1'b1; load_val = 4'd8;
        tick();
        n_tests++; if (w_cnt !== 4'd8) begin n_fail++; $display("FAIL load8 got %0d exp 8", w_cnt); end
        load = 1'b0; enable = 1'b1; step = 4'd3; up = 1'b1;
        tick();
        n_tests++; if (w_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_up_cnt got %0d exp 1", w_cnt); end
        n_tests++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_up_ovf got %0d exp 1", w_ovf); end
        enable = 1'b0;
        tick();
        n_tests++; if (w_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_up_hold got %0d exp 1", w_cnt); end
        n_tests++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_up_ovf_clr got %0d exp 0", w_ovf); end
    endtask

    task automatic test_wrap_down();
        enable = 1'b1; step = 4'd3; up = 1'b0;
        tick();
        n_tests++; if (w_cnt !== 4'd8) begin n_fail++; $display("FAIL wrap_dn_cnt got %0d exp 8", w_cnt); end
        n_tests++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_dn_ovf got %0d exp 1", w_ovf); end
        enable = 1'b0;
    endtask

    task automatic test_saturate();
        load = 1'b1; load_val = 4'd7; enable = 1'b0;
        tick();
        n_tests++; if (s_cnt !== 4'd7) begin n_fail++; $display("FAIL sat_load got %0d exp 7", s_cnt); end
        load = 1'b0; enable = 1'b1; step = 4'd5; up = 1'b1;
        tick();
        n_tests++; if (s_cnt !== 4'd9) begin n_fail++; $display("FAIL sat_up1_cnt got %0d exp 9", s_cnt); end
        n_tests++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_up1_ovf got %0d exp 1", s_ovf); end
        n_tests++; if (s_max !== 1'b1) begin n_fail++; $display("FAIL sat_up1_max got %0d exp 1", s_max); end
        n_tests++; if (w_cnt !== 4'd2) begin n_fail++; $display("FAIL wrap_7p5_cnt got %0d exp 2", w_cnt); end
        n_tests++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_7p5_ovf got %0d exp 1", w_ovf); end
        tick();
        n_tests++; if (s_cnt !== 4'd9) begin n_fail++; $display("FAIL sat_up2_cnt got %0d exp 9", s_cnt); end
        n_tests++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_up2_ovf got %0d exp 1", s_ovf); end
        n_tests++; if (w_cnt !== 4'd7) begin n_fail++; $display("FAIL wrap_2p5_cnt got %0d exp 7", w_cnt); end
        n_tests++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_2p5_ovf got %0d exp 0", w_ovf); end
        up = 1'b0; step = 4'd9;
        tick();
        n_tests++; if (s_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_dn_cnt got %0d exp 0", s_cnt); end
        n_tests++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_dn_ovf got %0d exp 0", s_ovf); end
        n_tests++; if (s_zero !== 1'b1) begin n_fail++; $display("FAIL sat_dn_zero got %0d exp 1", s_zero); end
        n_tests++; if (w_cnt !== 4'd8) begin n_fail++; $display("FAIL wrap_7m9_cnt got %0d exp 8", w_cnt); end
        n_tests++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_7m9_ovf got %0d exp 1", w_ovf); end
        tick();
        n_tests++; if (s_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_floor_cnt got %0d exp 0", s_cnt); end
        n_tests++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_floor_ovf got %0d exp 1", s_ovf); end
        enable = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 4'd12; enable = 1'b1; up = 1'b1; step = 4'd1;
        tick();
        n_tests++; if (w_cnt !== 4'd9) begin n_fail++; $display("FAIL load_clamp got %0d exp 9", w_cnt); end
        n_tests++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL load_ovf got %0d exp 0", w_ovf); end
        n_tests++; if (w_max !== 1'b1) begin n_fail++; $display("FAIL load_max got %0d exp 1", w_max); end
        load_val = 4'd5;
        tick();
        n_tests++; if (w_cnt !== 4'd5) begin n_fail++; $display("FAIL load5 got %0d exp 5", w_cnt); end
        n_tests++; if (s_cnt !== 4'd5) begin n_fail++; $display("FAIL load5_sat got %0d exp 5", s_cnt); end
        load = 1'b0;
    endtask

    task automatic test_step_zero();
        enable = 1'b1; step = 4'd0; up = 1'b1;
        tick();
        n_tests++; if (w_cnt !== 4'd5) begin n_fail++; $display("FAIL step0_up got %0d exp 5", w_cnt); end
        up = 1'b0;
        tick();
        n_tests++; if (w_cnt !== 4'd5) begin n_fail++; $display("FAIL step0_dn got %0d exp 5", w_cnt); end
        n_tests++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL step0_ovf got %0d exp 0", w_ovf); end
        enable = 1'b0;
    endtask

    task automatic test_mid_reset();
        load = 1'b1; load_val = 4'd6;
        tick();
        load = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd1; rst_n = 1'b0;
        tick();
        n_tests++; if (w_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d exp 0", w_cnt); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (w_cnt !== 4'd1) begin n_fail++; $display("FAIL mid_rst_1 got %0d exp 1", w_cnt); end
        tick();
        n_tests++; if (w_cnt !== 4'd2) begin n_fail++; $display("FAIL mid_rst_2 got %0d exp 2", w_cnt); end
        enable = 1'b0;
        tick(); tick();
        n_tests++; if (w_cnt !== 4'd2) begin n_fail++; $display("FAIL mid_rst_hold got %0d exp 2", w_cnt); end
    endtask

    task automatic test_reset_no_clock();
        rst_n = 1'b0;
        #3;
        n_tests++; if (w_cnt !== 4'd2) begin n_fail++; $display("FAIL async_rst got %0d exp 2", w_cnt); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (w_cnt !== 4'd2) begin n_fail++; $display("FAIL after_glitch got %0d exp 2", w_cnt); end
    endtask

    task automatic test_full_step();
        enable = 1'b1; up = 1'b1; step = 4'd10;
        tick();
        n_tests++; if (w_cnt !== 4'd2) begin n_fail++; $display("FAIL full_rev_cnt got %0d exp 2", w_cnt); end
        n_tests++; if (w_ovf !== 1'b1) begin n_fail++; $display("FAIL full_rev_ovf got %0d exp 1", w_ovf); end
        n_tests++; if (s_cnt !== 4'd9) begin n_fail++; $display("FAIL full_rev_sat got %0d exp 9", s_cnt); end
        enable = 1'b0;
        tick();
        n_tests++; if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL full_rev_clr got %0d exp 0", w_ovf); end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_priority();
        test_step_zero();
        test_mid_reset();
        test_reset_no_clock();
        test_full_step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
